ysyx_22050612_dmem_resp: RTL and testbench
==========================================

Name: ysyx_22050612_dmem_resp

Overview:
- Data-memory responder: the target end of the load/store request interface driven by the execute/LSU side of the core.
- Accepts one request at a time over a valid/ready channel and performs a 64-bit read or a byte-masked write into an internal word array.
- Returns a response over a second valid/ready channel after a fixed, parameterised latency.
- Used as the simulated data memory in the core testbench and as the multi-cycle memory model for bringing up the LSU.

Parameters:
DEPTH, 1024, number of 64-bit words in the array (power of two)
LATENCY, 2, cycles from request acceptance to rsp_valid rising; legal range 1..15
BASE, 64'h8000_0000, byte address of word 0

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_wen  in  1  1 = write, 0 = read
req_addr  in  64  byte address; bits [2:0] ignored for word select
req_wdata  in  64  write data
req_wmask  in  8  byte enables for writes; bit i enables byte i
rsp_valid  out  1  response present
rsp_ready  in  1  requester accepts response
rsp_rdata  out  64  read data; 0 for writes and for errors
rsp_err  out  1  address out of range

Behaviour:
- Reset (async assert, sync release): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter 0. Array contents are not reset.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch wen/addr/wdata/wmask, load the counter with LATENCY-1, then go to WAIT; if LATENCY==1, go directly to RESP.
  - WAIT: req_ready=0. Decrement the counter each cycle; go to RESP on the cycle the counter reaches 0.
  - RESP: rsp_valid=1 and req_ready=0. When rsp_ready=1, go to IDLE and clear rsp_valid.
- Latency: the acceptance edge is cycle 0; rsp_valid is high from cycle LATENCY onward.
- Throughput: at most one transaction per LATENCY+1 cycles (IDLE→RESP→IDLE, with no accept in the RESP-exit cycle).
- Range check: in range iff BASE <= addr < BASE+DEPTH*8, with unsigned 64-bit compare and no wrap. Word index = (addr-BASE)>>3, truncated to log2(DEPTH) bits.
- Read: array word is sampled on the edge entering RESP and held in rsp_rdata; rsp_err=0.
- Write: each byte with wmask[i]=1 is committed on the edge entering RESP; rsp_rdata=0, rsp_err=0. wmask=0 is legal and writes nothing.
- Error (out of range): no array access, rsp_rdata=0, rsp_err=1. Timing is identical to a normal access.
- rsp_rdata and rsp_err stay stable while rsp_valid=1 and rsp_ready=0 (backpressure holds indefinitely).
- req_valid during WAIT/RESP is ignored; the requester must hold it until req_ready.
- Reset mid-transaction: the pending request is dropped. A write is not committed unless the RESP-entry edge has already occurred.
- rsp_rdata/rsp_err are cleared to 0 on leaving RESP.

Decomposition:
- Shared package/include:
  - state encoding constants ST_IDLE=2'd0, ST_WAIT=2'd1, ST_RESP=2'd2
  - XLEN=64
  - byte-mask width 8
- Sub-module ysyx_22050612_dmem_array (DEPTH x 64):
  - synchronous write with 8 byte-enables
  - combinational read by index
  - instantiated once
- FSM, counter, range check and response registers live in the top module.

Test Plan:
- Reset, then read 0x8000_0000 (array preloaded 64'h1122334455667788) with LATENCY=2, rsp_ready=1 → req_ready drops at cycle 1, rsp_valid=1 at cycle 2, rsp_rdata=64'h1122334455667788, rsp_err=0, req_ready=1 at cycle 3.
- Write 0x8000_0008 wdata=64'hFFFF_FFFF_FFFF_FFFF wmask=8'h0F over prior 0, then read back → rsp_rdata=64'h0000_0000_FFFF_FFFF; the write response has rsp_rdata=0.
- Read 0x7FFF_FFF8 and 0x8000_2000 (DEPTH=1024) → rsp_err=1, rsp_rdata=0, array unchanged; timing identical to a normal read.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_rdata stable all 5 cycles; req_valid pulses are ignored (req_ready=0); exactly one response is delivered.
- Assert rst_n=0 during WAIT of a write to 0x8000_0010 → outputs return to reset values immediately; a subsequent read of 0x8000_0010 returns the old value.
- LATENCY=1 build: back-to-back reads with rsp_ready=1 → rsp_valid one cycle after each accept; one accept every 2 cycles.

Source files
------------

// File: rtl/ysyx_22050612_dmem_resp_pkg.sv
// Shared types and constants for the data-memory responder: state encoding,
// bus widths and the address range helper.
package ysyx_22050612_dmem_resp_pkg;

    localparam int XLEN   = 64;
    localparam int MASK_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // The difference form cannot overflow, so base+span may reach the top of the space.
    function automatic logic addr_in_range(input logic [XLEN-1:0] addr,
                                           input logic [XLEN-1:0] base,
                                           input logic [XLEN-1:0] span);
        return (addr >= base) && ((addr - base) < span);
    endfunction

endpackage

// File: rtl/ysyx_22050612_dmem_resp_if.sv
// Load/store request and response channels between the LSU (master) and the
// data memory (slave).
interface ysyx_22050612_dmem_resp_if;
    import ysyx_22050612_dmem_resp_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/ysyx_22050612_dmem_array.sv
// DEPTH x 64-bit word store: byte-enabled synchronous write, combinational read.
// Contents are deliberately not reset.
module ysyx_22050612_dmem_array
    import ysyx_22050612_dmem_resp_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [MASK_W-1:0] wmask,
    input  logic [IDX_W-1:0]  idx,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (wmask[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ysyx_22050612_dmem.sv
// Data-memory responder: one request at a time, fixed LATENCY to response,
// response held under backpressure until rsp_ready.
module ysyx_22050612_dmem_resp
    import ysyx_22050612_dmem_resp_pkg::*;
#(
    parameter int              DEPTH   = 1024,
    parameter int              LATENCY = 2,
    parameter logic [XLEN-1:0] BASE    = 64'h8000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    ysyx_22050612_dmem_resp_if.slave     bus
);

    localparam int              IDX_W = $clog2(DEPTH);
    localparam logic [XLEN-1:0] SPAN  = XLEN'(DEPTH) << 3;
    localparam bit              LAT1  = (LATENCY == 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              req_ready_r, rsp_valid_r, rsp_err_r;
    logic [XLEN-1:0]   rsp_rdata_r;

    logic              q_wen, q_err;
    logic [IDX_W-1:0]  q_idx;
    logic [XLEN-1:0]   q_wdata;
    logic [MASK_W-1:0] q_wmask;

    logic              accept, in_err, enter_resp;
    logic [IDX_W-1:0]  in_idx;
    logic              e_wen, e_err, arr_we;
    logic [IDX_W-1:0]  e_idx;
    logic [XLEN-1:0]   e_wdata, arr_rdata;
    logic [MASK_W-1:0] e_wmask;

    // With LATENCY==1 the RESP-entry edge is the acceptance edge, so the array
    // must see the live request rather than the latched copy.
    always_comb begin
        accept     = (state == ST_IDLE) && bus.req_valid && req_ready_r;
        in_err     = !addr_in_range(bus.req_addr, BASE, SPAN);
        in_idx     = IDX_W'((bus.req_addr - BASE) >> 3);
        enter_resp = LAT1 ? accept : ((state == ST_WAIT) && (cnt == 4'd1));
        e_wen      = LAT1 ? bus.req_wen   : q_wen;
        e_err      = LAT1 ? in_err        : q_err;
        e_idx      = LAT1 ? in_idx        : q_idx;
        e_wdata    = LAT1 ? bus.req_wdata : q_wdata;
        e_wmask    = LAT1 ? bus.req_wmask : q_wmask;
        arr_we     = enter_resp && e_wen && !e_err;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            q_wen   <= bus.req_wen;
            q_err   <= in_err;
            q_idx   <= in_idx;
            q_wdata <= bus.req_wdata;
            q_wmask <= bus.req_wmask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
        end else if (enter_resp) begin
            state       <= ST_RESP;
            cnt         <= 4'd0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= e_err;
            rsp_rdata_r <= (e_wen || e_err) ? '0 : arr_rdata;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    state       <= ST_WAIT;
                    req_ready_r <= 1'b0;
                    cnt         <= 4'(LATENCY - 1);
                end
                ST_WAIT: cnt <= cnt - 4'd1;
                ST_RESP: if (bus.rsp_ready) begin
                    state       <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_rdata_r <= '0;
                    rsp_err_r   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ysyx_22050612_dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .wmask (e_wmask),
        .idx   (e_idx),
        .wdata (e_wdata),
        .rdata (arr_rdata)
    );

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_ysyx_22050612_dmem_resp.sv
// Bench for the data-memory responder: a LATENCY=2 and a LATENCY=1 instance,
// each with its own expected-response queue fed from a small memory model.
module tb_ysyx_22050612_dmem_resp;
    import ysyx_22050612_dmem_resp_pkg::*;

    localparam int          DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    logic [64:0] qa[$];
    logic [64:0] qb[$];
    logic [63:0] mdl_a [DEPTH];
    logic [63:0] mdl_b [DEPTH];

    ysyx_22050612_dmem_resp_if a_if();
    ysyx_22050612_dmem_resp_if b_if();

    ysyx_22050612_dmem_resp #(.DEPTH(DEPTH), .LATENCY(2), .BASE(BASE)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    ysyx_22050612_dmem_resp #(.DEPTH(DEPTH), .LATENCY(1), .BASE(BASE)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if.slave));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input bit sel, input bit wen, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [7:0] wmask);
        logic [64:0] e;
        logic [63:0] w;
        int idx;
        if (addr < BASE || addr >= BASE + 64'(DEPTH * 8)) begin
            e = {1'b1, 64'd0};
        end else begin
            idx = int'((addr - BASE) / 8);
            w = sel ? mdl_b[idx] : mdl_a[idx];
            if (wen) begin
                for (int i = 0; i < 8; i++) if (wmask[i]) w[i*8 +: 8] = wdata[i*8 +: 8];
                if (sel) mdl_b[idx] = w; else mdl_a[idx] = w;
                e = {1'b0, 64'd0};
            end else begin
                e = {1'b0, w};
            end
        end
        if (sel) qb.push_back(e); else qa.push_back(e);
    endtask

    task automatic set_req(input bit sel, input bit v, input bit wen, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [7:0] wmask);
        if (sel) begin
            b_if.req_valid = v; b_if.req_wen = wen; b_if.req_addr = addr;
            b_if.req_wdata = wdata; b_if.req_wmask = wmask;
        end else begin
            a_if.req_valid = v; a_if.req_wen = wen; a_if.req_addr = addr;
            a_if.req_wdata = wdata; a_if.req_wmask = wmask;
        end
    endtask

    function automatic logic ready_of(input bit sel);
        return sel ? b_if.req_ready : a_if.req_ready;
    endfunction
    function automatic logic rvalid_of(input bit sel);
        return sel ? b_if.rsp_valid : a_if.rsp_valid;
    endfunction
    function automatic logic [63:0] rdata_of(input bit sel);
        return sel ? b_if.rsp_rdata : a_if.rsp_rdata;
    endfunction
    function automatic logic err_of(input bit sel);
        return sel ? b_if.rsp_err : a_if.rsp_err;
    endfunction

    // Issue one request, wait for acceptance and for rsp_valid; checks latency.
    task automatic send(input bit sel, input bit wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wmask, input string tag);
        int t;
        int lat;
        lat = sel ? 1 : 2;
        push_exp(sel, wen, addr, wdata, wmask);
        set_req(sel, 1'b1, wen, addr, wdata, wmask);
        t = 0;
        while (!ready_of(sel) && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) check_eq({tag, "_accept_timeout"}, 64'(t), 64'd0);
        @(posedge clk); #1;
        set_req(sel, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        check_eq({tag, "_ready_drop"}, 64'(ready_of(sel)), 64'd0);
        t = 1;
        while (!rvalid_of(sel) && t < 100) begin @(posedge clk); #1; t++; end
        check_eq({tag, "_latency"}, 64'(t), 64'(lat));
    endtask

    // One cycle after the response with rsp_ready=1 the responder is idle and cleared.
    task automatic complete(input bit sel, input string tag);
        @(posedge clk); #1;
        check_eq({tag, "_idle_ready"}, 64'(ready_of(sel)), 64'd1);
        check_eq({tag, "_idle_valid"}, 64'(rvalid_of(sel)), 64'd0);
        check_eq({tag, "_idle_rdata"}, rdata_of(sel), 64'd0);
    endtask

    logic [64:0] ea, eb;
    always @(negedge clk) begin
        if (rst_n && a_if.rsp_valid && a_if.rsp_ready) begin
            check_eq("a_sb_pending", 64'(qa.size() != 0), 64'd1);
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                check_eq("a_rdata", a_if.rsp_rdata, ea[63:0]);
                check_eq("a_err", 64'(a_if.rsp_err), 64'(ea[64]));
            end
        end
        if (rst_n && b_if.rsp_valid && b_if.rsp_ready) begin
            check_eq("b_sb_pending", 64'(qb.size() != 0), 64'd1);
            if (qb.size() != 0) begin
                eb = qb.pop_front();
                check_eq("b_rdata", b_if.rsp_rdata, eb[63:0]);
                check_eq("b_err", 64'(b_if.rsp_err), 64'(eb[64]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [63:0] b2b_addr [4];

    initial begin
        set_req(0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        set_req(1, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        a_if.rsp_ready = 1'b1;
        b_if.rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check_eq($sformatf("rst%0d_ready", s), 64'(ready_of(s[0])), 64'd1);
            check_eq($sformatf("rst%0d_valid", s), 64'(rvalid_of(s[0])), 64'd0);
            check_eq($sformatf("rst%0d_rdata", s), rdata_of(s[0]), 64'd0);
            check_eq($sformatf("rst%0d_err", s), 64'(err_of(s[0])), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(0, 1, BASE,      64'h1122334455667788, 8'hFF, "pre0"); complete(0, "pre0");
        send(0, 1, BASE + 8,  64'd0,                8'hFF, "pre1"); complete(0, "pre1");
        send(0, 1, BASE + 24, 64'hDEADBEEF0BADF00D, 8'hFF, "pre3"); complete(0, "pre3");

        send(0, 0, BASE, 64'd0, 8'd0, "rd0");
        check_eq("rd0_const", a_if.rsp_rdata, 64'h1122334455667788);
        complete(0, "rd0");

        send(0, 1, BASE + 8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, "wr_part");
        check_eq("wr_part_rdata0", a_if.rsp_rdata, 64'd0);
        complete(0, "wr_part");
        send(0, 0, BASE + 8, 64'd0, 8'd0, "rd_part");
        check_eq("rd_part_const", a_if.rsp_rdata, 64'h0000_0000_FFFF_FFFF);
        complete(0, "rd_part");

        send(0, 1, BASE + 8, 64'h1234_5678_9ABC_DEF0, 8'h00, "wr_nomask"); complete(0, "wr_nomask");
        send(0, 0, BASE + 8, 64'd0, 8'd0, "rd_nomask"); complete(0, "rd_nomask");

        send(0, 1, BASE + 64'h1FF8, 64'hCAFE_F00D_1357_9BDF, 8'hFF, "wr_last"); complete(0, "wr_last");
        send(0, 0, BASE + 64'h1FF8, 64'd0, 8'd0, "rd_last"); complete(0, "rd_last");

        send(0, 0, 64'h7FFF_FFF8, 64'd0, 8'd0, "err_lo");
        check_eq("err_lo_flag", 64'(a_if.rsp_err), 64'd1);
        complete(0, "err_lo");
        send(0, 0, 64'h8000_2000, 64'd0, 8'd0, "err_hi");
        check_eq("err_hi_flag", 64'(a_if.rsp_err), 64'd1);
        complete(0, "err_hi");
        send(0, 1, 64'h8000_2000, 64'hFFFF_0000_FFFF_0000, 8'hFF, "err_wr"); complete(0, "err_wr");
        send(0, 0, BASE, 64'd0, 8'd0, "rd0_after_err"); complete(0, "rd0_after_err");

        // Backpressure: response held for five cycles while stray requests are offered.
        a_if.rsp_ready = 1'b0;
        send(0, 0, BASE, 64'd0, 8'd0, "bp");
        for (int k = 0; k < 5; k++) begin
            set_req(0, (k % 2) == 0, 1'b1, BASE + 24, 64'h0, 8'hFF);
            @(posedge clk); #1;
            check_eq($sformatf("bp%0d_valid", k), 64'(a_if.rsp_valid), 64'd1);
            check_eq($sformatf("bp%0d_rdata", k), a_if.rsp_rdata, 64'h1122334455667788);
            check_eq($sformatf("bp%0d_ready", k), 64'(a_if.req_ready), 64'd0);
        end
        set_req(0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        a_if.rsp_ready = 1'b1;
        complete(0, "bp");
        check_eq("bp_delivered_once", 64'(qa.size()), 64'd0);
        send(0, 0, BASE + 24, 64'd0, 8'd0, "rd3_after_bp"); complete(0, "rd3_after_bp");

        // Reset while a write sits in WAIT: the write must be dropped.
        send(0, 1, BASE + 16, 64'hA5A5_5A5A_A5A5_5A5A, 8'hFF, "pre2"); complete(0, "pre2");
        set_req(0, 1'b1, 1'b1, BASE + 16, 64'h0123_4567_89AB_CDEF, 8'hFF);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        check_eq("mid_wait_ready", 64'(a_if.req_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ready", 64'(a_if.req_ready), 64'd1);
        check_eq("mid_rst_valid", 64'(a_if.rsp_valid), 64'd0);
        check_eq("mid_rst_rdata", a_if.rsp_rdata, 64'd0);
        check_eq("mid_rst_err", 64'(a_if.rsp_err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(0, 0, BASE + 16, 64'd0, 8'd0, "rd2_after_rst");
        check_eq("rd2_after_rst_const", a_if.rsp_rdata, 64'hA5A5_5A5A_A5A5_5A5A);
        complete(0, "rd2_after_rst");

        // LATENCY=1 instance: preload, then back-to-back reads with req_valid held.
        send(1, 1, BASE,     64'h0102_0304_0506_0708, 8'hFF, "b_pre0"); complete(1, "b_pre0");
        send(1, 1, BASE + 8, 64'hF0E0_D0C0_B0A0_9080, 8'hFF, "b_pre1"); complete(1, "b_pre1");
        b2b_addr[0] = BASE; b2b_addr[1] = BASE + 8; b2b_addr[2] = BASE + 8; b2b_addr[3] = BASE;
        push_exp(1, 0, b2b_addr[0], 64'd0, 8'd0);
        set_req(1, 1'b1, 1'b0, b2b_addr[0], 64'd0, 8'd0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check_eq($sformatf("b2b%0d_valid", k), 64'(b_if.rsp_valid), 64'((k % 2) == 0));
            check_eq($sformatf("b2b%0d_ready", k), 64'(b_if.req_ready), 64'((k % 2) == 1));
            if ((k % 2) == 0) begin
                if (k < 6) begin
                    push_exp(1, 0, b2b_addr[k/2 + 1], 64'd0, 8'd0);
                    set_req(1, 1'b1, 1'b0, b2b_addr[k/2 + 1], 64'd0, 8'd0);
                end else begin
                    set_req(1, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("a_sb_drained", 64'(qa.size()), 64'd0);
        check_eq("b_sb_drained", 64'(qb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
